// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: the carry chain is cut into STAGES
// segments of SEG bits, one segment resolved per register stage, with a global stall.
module pipelined_rca #(
  parameter int BITS   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            ovf,
  output logic            zero
);
  localparam int SEG = BITS / STAGES;

  logic            w_advance;
  logic [BITS-1:0] w_b_eff;
  logic            w_cin_eff;
  logic [BITS-1:0] r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;

  // Subtraction is a + ~b + 1, so the inversion and forced carry happen before stage 0.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : cin;

  assign out_valid = g_stage[STAGES-1].r_valid;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * SEG;
      localparam int REM = BITS - LO;

      logic [REM-1:0]    w_a_in;
      logic [REM-1:0]    w_b_in;
      logic              w_c_in;
      logic              w_valid_in;
      logic [SEG:0]      w_seg;
      logic [LO+SEG-1:0] w_s_out;
      logic              r_valid;

      if (gi == 0) begin : g_head
        assign w_a_in     = a;
        assign w_b_in     = w_b_eff;
        assign w_c_in     = w_cin_eff;
        assign w_valid_in = in_valid;
        assign w_s_out    = w_seg[SEG-1:0];
      end else begin : g_tail
        assign w_a_in     = g_stage[gi-1].g_mid.r_a_rem;
        assign w_b_in     = g_stage[gi-1].g_mid.r_b_rem;
        assign w_c_in     = g_stage[gi-1].g_mid.r_c;
        assign w_valid_in = g_stage[gi-1].r_valid;
        assign w_s_out    = {w_seg[SEG-1:0], g_stage[gi-1].g_mid.r_s};
      end

      // Only the lowest unconsumed segment is added here; higher bits ride along.
      assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]} + {{SEG{1'b0}}, w_c_in};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
        end else if (w_advance) begin
          r_valid <= w_valid_in;
        end
      end

      if (gi < STAGES - 1) begin : g_mid
        logic [REM-SEG-1:0] r_a_rem;
        logic [REM-SEG-1:0] r_b_rem;
        logic [LO+SEG-1:0]  r_s;
        logic               r_c;

        always_ff @(posedge clk) begin
          if (w_advance) begin
            r_a_rem <= w_a_in[REM-1:SEG];
            r_b_rem <= w_b_in[REM-1:SEG];
            r_s     <= w_s_out;
            r_c     <= w_seg[SEG];
          end
        end
      end else begin : g_last
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
          end else if (w_advance) begin
            r_sum  <= w_s_out;
            r_cout <= w_seg[SEG];
            r_ovf  <= (w_a_in[REM-1] == w_b_in[REM-1]) && (w_s_out[BITS-1] != w_a_in[REM-1]);
            r_zero <= (w_s_out == '0);
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca at BITS=8, STAGES=2: directed table, stall and reset
// sequences, then a randomized handshake run against an arithmetic reference model.
module tb_pipelined_rca;
  localparam int BITS   = 8;
  localparam int STAGES = 2;
  localparam int N_RND  = 10000;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [BITS-1:0] a         = '0;
  logic [BITS-1:0] b         = '0;
  logic            cin       = 1'b0;
  logic            sub       = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] sum;
  logic            cout;
  logic            ovf;
  logic            zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } res_t;

  res_t exp_q[$];

  pipelined_rca #(.BITS(BITS), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic res_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic s);
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   u;
    int   sv;
    res_t r;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    if (s) begin
      u      = ua - ub;
      sv     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      u      = ua + ub + int'(c);
      sv     = sa + sb + int'(c);
      r.cout = (u > 255);
    end
    r.sum  = u[7:0];
    r.ovf  = (sv > 127) || (sv < -128);
    r.zero = (r.sum == 8'h00);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string nm, input res_t e);
    chk(nm, 32'({cout, ovf, zero, sum}), 32'({e.cout, e.ovf, e.zero, e.sum}));
  endtask

  task automatic set_in(input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
    sub      = s;
  endtask

  vec_t tbl[9];
  res_t e;
  int   n_acc;
  int   n_pop;
  int   cyc;
  logic prev_hold;
  logic [11:0] prev_out;

  initial begin
    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{8'h33, 8'h33, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset, checked before any clock edge
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'({cout, ovf, zero, sum}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed table: each vector issued alone, latency checked cycle by cycle
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      #1 chk("tbl_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("tbl_lat1_idle", 32'(out_valid), 32'd0);
      @(negedge clk);
      #1 chk("tbl_lat2_valid", 32'(out_valid), 32'd1);
      e.sum  = tbl[i].sum;
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      e.zero = tbl[i].zero;
      chk_res("tbl_result", e);
      $display("vec %0d: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b zero=%b",
               i, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, sum, cout, ovf, zero);
      @(negedge clk);
    end

    // Back-to-back stream with a three-cycle output stall
    set_in(1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 8'h20, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 8'h30, 8'h03, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'h11);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("stall_release_ready", 32'(in_ready), 32'd1);
    chk("stream_first", 32'({out_valid, cout, sum}), 32'({1'b1, 1'b0, 8'h11}));
    $display("stream: sum=%h", sum);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("stream_second", 32'({out_valid, cout, sum}), 32'({1'b1, 1'b0, 8'h22}));
    $display("stream: sum=%h", sum);
    @(negedge clk);
    #1 chk("stream_third", 32'({out_valid, cout, sum}), 32'({1'b1, 1'b0, 8'h33}));
    $display("stream: sum=%h", sum);
    @(negedge clk);
    #1 chk("stream_drained", 32'(out_valid), 32'd0);

    // Reset with two results in flight
    @(negedge clk);
    set_in(1'b1, 8'h44, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({cout, ovf, zero, sum}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    #1 chk("postrst_idle0", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("postrst_idle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("postrst_valid", 32'(out_valid), 32'd1);
    chk_res("postrst_result", model(8'h12, 8'h34, 1'b1, 1'b0));
    $display("postrst: sum=%h cout=%b", sum, cout);
    @(negedge clk);
    #1 chk("postrst_no_stale", 32'(out_valid), 32'd0);

    // Randomized handshake run against the reference model
    exp_q.delete();
    n_acc     = 0;
    n_pop     = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    prev_out  = '0;
    while ((n_acc < N_RND || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (n_acc < N_RND) in_valid = ($urandom_range(0, 3) != 0);
      else               in_valid = 1'b0;
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = (n_acc >= N_RND) ? 1'b1 : ($urandom_range(0, 9) < 7);
      #1;
      if (prev_hold)
        chk("rnd_stall_stable", 32'({out_valid, cout, ovf, zero, sum}), 32'(prev_out));
      chk("rnd_in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rnd_extra: got unexpected result sum=%h, expected none", sum);
        end else begin
          e = exp_q.pop_front();
          chk_res("rnd_result", e);
          n_pop++;
          $display("rnd %0d: sum=%h cout=%b ovf=%b zero=%b", n_pop, sum, cout, ovf, zero);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_acc++;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {out_valid, cout, ovf, zero, sum};
    end
    chk("rnd_all_accepted", 32'(n_acc), 32'(N_RND));
    chk("rnd_all_delivered", 32'(n_pop), 32'(N_RND));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
